// File: rtl/jt12_snd_fifo.sv
// Sound output FIFO: captures the stereo accumulator at frame boundaries,
// scales/saturates each channel and buffers pairs behind a valid/ready port.
module jt12_snd_fifo #(
  parameter int ACC_WIDTH  = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int GAIN_SH    = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                        rst,
  input  logic                        clk,
  input  logic                        clk_en,
  input  logic                        zero,
  input  logic signed [ACC_WIDTH-1:0] left,
  input  logic signed [ACC_WIDTH-1:0] right,
  input  logic                        snd_ready,
  output logic                        snd_valid,
  output logic signed [OUT_WIDTH-1:0] snd_left,
  output logic signed [OUT_WIDTH-1:0] snd_right,
  input  logic                        clr_ovf,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt,
  output logic [DEPTH_LOG2:0]         level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EXT_W = ACC_WIDTH + GAIN_SH;
  // One guard bit above the wider of the shifted input and the output so the
  // shifted sample never wraps before it is compared against the limits.
  localparam int CMP_W = ((EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH) + 1;

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  function automatic logic signed [OUT_WIDTH-1:0] scale_sat(
    input logic signed [ACC_WIDTH-1:0] x
  );
    logic signed [CMP_W-1:0] wide;
    logic signed [OUT_WIDTH-1:0] res;
    wide = {{(CMP_W-ACC_WIDTH){x[ACC_WIDTH-1]}}, x};
    wide = wide <<< GAIN_SH;
    if (wide > SAT_MAX)
      res = SAT_MAX[OUT_WIDTH-1:0];
    else if (wide < SAT_MIN)
      res = SAT_MIN[OUT_WIDTH-1:0];
    else
      res = wide[OUT_WIDTH-1:0];
    return res;
  endfunction

  logic                        zero_d;
  logic                        cap;
  logic                        rd_en;
  logic                        wr_en;
  logic                        drop;
  logic [DEPTH_LOG2-1:0]       wr_ptr;
  logic [DEPTH_LOG2-1:0]       rd_ptr;
  logic signed [OUT_WIDTH-1:0] scaled_l;
  logic signed [OUT_WIDTH-1:0] scaled_r;
  logic signed [OUT_WIDTH-1:0] mem_l [DEPTH];
  logic signed [OUT_WIDTH-1:0] mem_r [DEPTH];
  logic signed [OUT_WIDTH-1:0] last_l;
  logic signed [OUT_WIDTH-1:0] last_r;

  // The accumulator holds the finished frame on the clk_en cycle after zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero_d <= 1'b0;
    else if (clk_en)
      zero_d <= zero;
  end

  assign cap      = clk_en & zero_d;
  assign snd_valid = (level != '0);
  assign rd_en    = snd_valid & snd_ready;
  assign wr_en    = cap & ((level != FULL_LEVEL) | rd_en);
  assign drop     = cap & ~wr_en;
  assign scaled_l = scale_sat(left);
  assign scaled_r = scale_sat(right);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_l[wr_ptr] <= scaled_l;
      mem_r[wr_ptr] <= scaled_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Once the FIFO runs dry the port keeps showing the most recently popped pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_l <= '0;
      last_r <= '0;
    end else if (rd_en) begin
      last_l <= mem_l[rd_ptr];
      last_r <= mem_r[rd_ptr];
    end
  end

  assign snd_left  = snd_valid ? mem_l[rd_ptr] : last_l;
  assign snd_right = snd_valid ? mem_r[rd_ptr] : last_r;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_jt12_snd_fifo.sv
// Directed self-checking bench for jt12_snd_fifo: capture, scaling,
// saturation, overflow accounting, clear priority and pointer wrap.
module tb_jt12_snd_fifo;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic              zero;
  logic signed [11:0] left;
  logic signed [11:0] right;
  logic              snd_ready;
  logic              clr_ovf;

  logic              snd_valid,  snd_valid6;
  logic signed [15:0] snd_left,   snd_left6;
  logic signed [15:0] snd_right,  snd_right6;
  logic              overflow,   overflow6;
  logic [7:0]        drop_cnt,   drop_cnt6;
  logic [2:0]        level,      level6;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jt12_snd_fifo #(.ACC_WIDTH(12), .OUT_WIDTH(16), .GAIN_SH(2), .DEPTH_LOG2(2)) u_dut (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .left(left), .right(right),
    .snd_ready(snd_ready), .snd_valid(snd_valid), .snd_left(snd_left),
    .snd_right(snd_right), .clr_ovf(clr_ovf), .overflow(overflow),
    .drop_cnt(drop_cnt), .level(level)
  );

  // Same stimulus at a higher gain to exercise the saturation limits.
  jt12_snd_fifo #(.ACC_WIDTH(12), .OUT_WIDTH(16), .GAIN_SH(6), .DEPTH_LOG2(2)) u_dut6 (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .left(left), .right(right),
    .snd_ready(snd_ready), .snd_valid(snd_valid6), .snd_left(snd_left6),
    .snd_right(snd_right6), .clr_ovf(clr_ovf), .overflow(overflow6),
    .drop_cnt(drop_cnt6), .level(level6)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture: zero on a clk_en cycle, idle gap, then the capturing clk_en cycle.
  task automatic applyStimulus(input int l, input int r, input logic rdy_pre,
                               input logic rdy_cap, input logic clr);
    left      = 12'(l);
    right     = 12'(r);
    zero      = 1'b1;
    clk_en    = 1'b1;
    snd_ready = rdy_pre;
    tick();
    zero      = 1'b0;
    clk_en    = 1'b0;
    snd_ready = 1'b0;
    repeat (5) tick();
    clk_en    = 1'b1;
    snd_ready = rdy_cap;
    clr_ovf   = clr;
    tick();
    clk_en    = 1'b0;
    snd_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic pop();
    snd_ready = 1'b1;
    tick();
    snd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; zero = 1'b0; left = '0; right = '0;
    snd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset asserted with a pair buffered
    applyStimulus(7, 7, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 32'(level), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(snd_valid), 0);
    checkOutput("rst_left", snd_left, 0);
    checkOutput("rst_right", snd_right, 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 0);
    checkOutput("rst_level", 32'(level), 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic capture with x4 gain
    applyStimulus(100, -50, 1'b0, 1'b0, 1'b0);
    checkOutput("cap_valid", 32'(snd_valid), 1);
    checkOutput("cap_left", snd_left, 400);
    checkOutput("cap_right", snd_right, -200);
    checkOutput("cap_level", 32'(level), 1);
    checkOutput("cap6_left", snd_left6, 6400);
    checkOutput("cap6_right", snd_right6, -3200);
    pop();
    checkOutput("empty_valid", 32'(snd_valid), 0);
    checkOutput("empty_hold_left", snd_left, 400);
    checkOutput("empty_hold_right", snd_right, -200);

    // Saturation at both extremes
    applyStimulus(2047, -2048, 1'b0, 1'b0, 1'b0);
    checkOutput("sat6_left", snd_left6, 32767);
    checkOutput("sat6_right", snd_right6, -32768);
    checkOutput("sat2_left", snd_left, 8188);
    checkOutput("sat2_right", snd_right, -8192);
    pop();

    // Fill beyond capacity
    for (int i = 1; i <= 6; i++)
      applyStimulus(i, -i, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_level", 32'(level), 4);
    checkOutput("fill_overflow", 32'(overflow), 1);
    checkOutput("fill_drop_cnt", 32'(drop_cnt), 2);
    checkOutput("fill_head", snd_left, 4);

    // Capture while full with a simultaneous read
    applyStimulus(9, -9, 1'b0, 1'b1, 1'b0);
    checkOutput("simul_level", 32'(level), 4);
    checkOutput("simul_drop_cnt", 32'(drop_cnt), 2);
    checkOutput("simul_head", snd_left, 8);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_left%0d", i), snd_left, (i < 3) ? 8 + 4 * i : 36);
      pop();
    end
    checkOutput("drain_valid", 32'(snd_valid), 0);
    checkOutput("drain_hold_right", snd_right, -36);

    // Clear versus drop
    for (int i = 1; i <= 5; i++)
      applyStimulus(i, -i, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_clr_drop_cnt", 32'(drop_cnt), 3);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checkOutput("clr_overflow", 32'(overflow), 0);
    checkOutput("clr_drop_cnt", 32'(drop_cnt), 0);
    applyStimulus(5, -5, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_drop_overflow", 32'(overflow), 1);
    checkOutput("clr_drop_cnt1", 32'(drop_cnt), 1);

    // Back-to-back zero strobes: one capture per clk_en cycle, all dropped
    zero   = 1'b1;
    clk_en = 1'b1;
    repeat (301) tick();
    zero   = 1'b0;
    clk_en = 1'b0;
    tick();
    checkOutput("sat_drop_cnt", 32'(drop_cnt), 255);
    checkOutput("sat_level", 32'(level), 4);
    checkOutput("sat_head", snd_left, 4);

    // Streaming through several pointer wraps
    repeat (4) pop();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    for (int k = 10; k < 30; k++) begin
      applyStimulus(k, -k, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("wrap_level%0d", k), 32'(level), 1);
      checkOutput($sformatf("wrap_left%0d", k), snd_left, 4 * k);
      if (k % 5 == 0)
        checkOutput($sformatf("wrap_right%0d", k), snd_right, -4 * k);
    end
    pop();
    checkOutput("wrap_end_level", 32'(level), 0);
    checkOutput("wrap_end_hold", snd_left, 116);
    checkOutput("wrap_overflow", 32'(overflow), 0);
    checkOutput("wrap_drop_cnt", 32'(drop_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
